// File: rtl/hue_fade_engine.sv
// hue_fade_engine: hue-wheel or breathing colour generator with brightness scaling and live-cell gating
module hue_fade_engine #(
   parameter int COLOR_W  = 8,
   parameter int TICK_DIV = 10000,
   parameter int STEP     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic                 mode_i,
   input  logic [COLOR_W-1:0]   brightness_i,
   input  logic [3*COLOR_W-1:0] base_color_i,
   input  logic                 pixel_value_i,
   output logic [3*COLOR_W-1:0] colored_pixel_value_o,
   output logic [2:0]           segment_o,
   output logic                 tick_o
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [COLOR_W-1:0] MAX = {COLOR_W{1'b1}};
   localparam logic [COLOR_W-1:0] STEP_V = COLOR_W'(STEP);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
   logic [PW-1:0]        presc_q, presc_d;
   logic                 tick_q, tick_d;
   logic [COLOR_W-1:0]   level_q, level_d;
   logic [2:0]           seg_q, seg_d;
   logic                 up_q, up_d;
   logic                 mode_q;
   logic [3*COLOR_W-1:0] pix_q, pix_d;
   logic [COLOR_W:0]     sum;
   logic [COLOR_W-1:0]   lvl_up, lvl_dn, inv_l;
   logic [COLOR_W-1:0]   r_hue, g_hue, b_hue, r_raw, g_raw, b_raw;

   function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] a, input logic [COLOR_W-1:0] b);
      logic [2*COLOR_W-1:0] p;
      p = {{COLOR_W{1'b0}}, a} * {{COLOR_W{1'b0}}, b} + {{COLOR_W{1'b0}}, MAX};
      return p[2*COLOR_W-1:COLOR_W];
   endfunction

   assign sum    = {1'b0, level_q} + {1'b0, STEP_V};
   assign lvl_up = (sum > {1'b0, MAX}) ? MAX : sum[COLOR_W-1:0];
   assign lvl_dn = (level_q > STEP_V) ? level_q - STEP_V : '0;
   assign inv_l  = MAX - level_q;

   // Prescaler, tick strobe and ramp state; a mode change restarts everything from a clean ramp
   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      level_d = level_q;
      seg_d   = seg_q;
      up_d    = up_q;
      if (mode_i != mode_q) begin
         presc_d = '0;
         level_d = '0;
         seg_d   = '0;
         up_d    = 1'b1;
      end else if (enable_i) begin
         presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
         tick_d  = presc_q == LAST;
         if (tick_q && !mode_i) begin
            level_d = (level_q == MAX) ? '0 : lvl_up;
            seg_d   = (level_q != MAX) ? seg_q : (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
         end else if (tick_q) begin
            level_d = up_q ? lvl_up : lvl_dn;
            up_d    = up_q ? (lvl_up != MAX) : (lvl_dn == '0);
         end
      end
   end

   assign r_hue = (seg_q == 3'd0 || seg_q == 3'd5) ? MAX : (seg_q == 3'd1) ? inv_l : (seg_q == 3'd4) ? level_q : '0;
   assign g_hue = (seg_q == 3'd1 || seg_q == 3'd2) ? MAX : (seg_q == 3'd0) ? level_q : (seg_q == 3'd3) ? inv_l : '0;
   assign b_hue = (seg_q == 3'd3 || seg_q == 3'd4) ? MAX : (seg_q == 3'd2) ? level_q : (seg_q == 3'd5) ? inv_l : '0;

   // Raw colour from the active mode, then global brightness, then live-cell gating
   always_comb begin
      r_raw = mode_i ? scale(base_color_i[2*COLOR_W-1:COLOR_W], level_q) : r_hue;
      g_raw = mode_i ? scale(base_color_i[3*COLOR_W-1:2*COLOR_W], level_q) : g_hue;
      b_raw = mode_i ? scale(base_color_i[COLOR_W-1:0], level_q) : b_hue;
      pix_d = pixel_value_i ? {scale(g_raw, brightness_i), scale(r_raw, brightness_i), scale(b_raw, brightness_i)} : '0;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         level_q <= '0;
         seg_q   <= '0;
         up_q    <= 1'b1;
         mode_q  <= 1'b0;
         pix_q   <= '0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         level_q <= level_d;
         seg_q   <= seg_d;
         up_q    <= up_d;
         mode_q  <= mode_i;
         pix_q   <= pix_d;
      end
   end

   assign colored_pixel_value_o = pix_q;
   assign segment_o             = seg_q;
   assign tick_o                = tick_q;
endmodule
